// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: arbitrates credit and message display requests, converts
// the selected 20-bit binary value to six BCD digits by serial double-dabble,
// and drives the digit inputs of a seven-segment display.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   cr_req/cr_val       credit display request (level) and binary value
//   cr_ack              one-cycle pulse when cr_val is captured
//   msg_req/msg_val     priority message request (level) and binary value
//   msg_ack             one-cycle pulse when msg_val is captured
//   blank               forces all digit outputs to 4'hF (output-only effect)
//   dig5..dig0          BCD digits, dig5 most significant, 4'hF = blank digit
//   busy                high while the FSM is not idle
//   ovf                 last committed value was saturated to 999999
module seg_display_ctrl #(
  parameter int unsigned MSG_HOLD = 16,
  parameter int unsigned LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cr_req,
  input  logic [19:0] cr_val,
  output logic        cr_ack,
  input  logic        msg_req,
  input  logic [19:0] msg_val,
  output logic        msg_ack,
  input  logic        blank,
  output logic [3:0]  dig5,
  output logic [3:0]  dig4,
  output logic [3:0]  dig3,
  output logic [3:0]  dig2,
  output logic [3:0]  dig1,
  output logic [3:0]  dig0,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned BIN_W  = 20;
  localparam int unsigned BCD_W  = 24;
  localparam int unsigned NDIG   = 6;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned HOLD_W = 16;

  localparam logic [BIN_W-1:0]  SAT_MAX    = BIN_W'(999999);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MSG_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_COMMIT,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic               src_msg_q, src_msg_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BIN_W-1:0]   last_cr_q, last_cr_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               cr_ack_q, cr_ack_d;
  logic               msg_ack_q, msg_ack_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_sh;
  logic [BIN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   dig_fmt;
  logic               lead;
  logic               go_msg, go_cr, go_reload;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_sh = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_sh = {bin_q[BIN_W-2:0], 1'b0};
  end

  // Leading-zero blanking; dig0 is never blanked so zero shows as a single 0.
  always_comb begin
    dig_fmt = bcd_q;
    lead    = 1'b1;
    for (int i = int'(NDIG) - 1; i >= 1; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
        if (LZ_BLANK != 0) begin
          dig_fmt[4*i +: 4] = 4'hF;
        end
      end else begin
        lead = 1'b0;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    src_msg_d  = src_msg_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    last_cr_d  = last_cr_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    dig_d      = dig_q;
    cr_ack_d   = 1'b0;
    msg_ack_d  = 1'b0;
    go_msg     = 1'b0;
    go_cr      = 1'b0;
    go_reload  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (msg_req) begin
          go_msg = 1'b1;
        end else if (cr_req) begin
          go_cr = 1'b1;
        end
      end
      S_LOAD: begin
        ovf_pend_d = (bin_q > SAT_MAX);
        if (bin_q > SAT_MAX) begin
          bin_d = SAT_MAX;
        end
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SHIFT) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        dig_d   = dig_fmt;
        ovf_d   = ovf_pend_q;
        hold_d  = '0;
        state_d = src_msg_q ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        // A new message preempts the hold; credit waits for expiry.
        if (msg_req) begin
          go_msg = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          if (cr_req) begin
            go_cr = 1'b1;
          end else begin
            go_reload = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_msg) begin
      bin_d     = msg_val;
      src_msg_d = 1'b1;
      msg_ack_d = 1'b1;
      state_d   = S_LOAD;
    end else if (go_cr) begin
      bin_d     = cr_val;
      last_cr_d = cr_val;
      src_msg_d = 1'b0;
      cr_ack_d  = 1'b1;
      state_d   = S_LOAD;
    end else if (go_reload) begin
      // Restore the last credit value without a handshake.
      bin_d     = last_cr_q;
      src_msg_d = 1'b0;
      state_d   = S_LOAD;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      src_msg_q  <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      last_cr_q  <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      dig_q      <= '0;
      cr_ack_q   <= 1'b0;
      msg_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_msg_q  <= src_msg_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      last_cr_q  <= last_cr_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      dig_q      <= dig_d;
      cr_ack_q   <= cr_ack_d;
      msg_ack_q  <= msg_ack_d;
      busy_q     <= busy_d;
    end
  end

  // Blank overrides only the visible digits, never the stored ones.
  assign dig5    = blank ? 4'hF : dig_q[23:20];
  assign dig4    = blank ? 4'hF : dig_q[19:16];
  assign dig3    = blank ? 4'hF : dig_q[15:12];
  assign dig2    = blank ? 4'hF : dig_q[11:8];
  assign dig1    = blank ? 4'hF : dig_q[7:4];
  assign dig0    = blank ? 4'hF : dig_q[3:0];
  assign cr_ack  = cr_ack_q;
  assign msg_ack = msg_ack_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule
